// File: rtl/freepdk45_sram_pkg.sv
// Shared types and helpers for the parameterised 1W1R SRAM macro model.
package freepdk45_sram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } sram_state_t;

    // Bits per write lane; callers guarantee data_w is a multiple of lanes.
    function automatic int lane_width(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

endpackage

// File: rtl/freepdk45_sram_clear_fsm.sv
// Post-reset sweep that zeroes the array one word per cycle, then raises ready.
module freepdk45_sram_clear_fsm
    import freepdk45_sram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_ready,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam sram_state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    sram_state_t           r_state;
    sram_state_t           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_clr_we    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                o_clr_we  = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_cnt_nxt = r_cnt;
            end
        endcase
    end

    assign o_ready    = (r_state == ST_READY);
    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/freepdk45_sram_1w1r_param.sv
// Behavioural 1-write/1-read SRAM with lane masks, write-first bypass and
// optional output register.
module freepdk45_sram_1w1r_param
    import freepdk45_sram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int WMASK_WIDTH    = 4,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk0,
    input  logic                   rstb0,
    output logic                   ready0,
    input  logic                   csb0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dvalid1
);

    localparam int LANE_W = lane_width(DATA_WIDTH, WMASK_WIDTH);
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    logic                  w_ready;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_bitmask;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_vld_last;
    logic [DATA_WIDTH-1:0] w_data_last;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dvalid;

    freepdk45_sram_clear_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_fsm (
        .i_clk      (clk0),
        .i_rst_n    (rstb0),
        .o_ready    (w_ready),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign w_wr_en = w_ready & ~csb0;
    assign w_rd_en = w_ready & ~csb1;

    always_comb begin
        w_bitmask = '0;
        for (int i = 0; i < WMASK_WIDTH; i++) begin
            w_bitmask[i*LANE_W +: LANE_W] = {LANE_W{wmask0[i]}};
        end
    end

    // Write-first on a same-address collision: enabled lanes see din0.
    always_comb begin
        w_rd_data = r_mem[addr1];
        if (w_wr_en && (addr0 == addr1)) begin
            w_rd_data = (r_mem[addr1] & ~w_bitmask) | (din0 & w_bitmask);
        end
    end

    // Array has no reset; only the clear sweep zeroes it.
    always_ff @(posedge clk0) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (wmask0[i]) begin
                    r_mem[addr0][i*LANE_W +: LANE_W] <= din0[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_vld_p0;
            logic [DATA_WIDTH-1:0] r_data_p0;

            always_ff @(posedge clk0 or negedge rstb0) begin
                if (!rstb0) begin
                    r_vld_p0 <= 1'b0;
                end else begin
                    r_vld_p0 <= w_rd_en;
                end
            end

            always_ff @(posedge clk0) begin
                if (w_rd_en) begin
                    r_data_p0 <= w_rd_data;
                end
            end

            assign w_vld_last  = r_vld_p0;
            assign w_data_last = r_data_p0;
        end else begin : g_no_out_reg
            assign w_vld_last  = w_rd_en;
            assign w_data_last = w_rd_data;
        end
    endgenerate

    // Output stage holds the last delivered word between reads.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            r_dvalid <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_dvalid <= w_vld_last;
            if (w_vld_last) begin
                r_dout <= w_data_last;
            end
        end
    end

    assign ready0  = w_ready;
    assign dout1   = r_dout;
    assign dvalid1 = r_dvalid;

endmodule

// File: tb/tb_freepdk45_sram_1w1r_param.sv
// Randomised bench for the 1W1R SRAM, both output-register options side by side.
module tb_freepdk45_sram_1w1r_param;

    logic        clk0 = 1'b0;
    logic        rstb0;
    logic        csb0, csb1;
    logic [3:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0;
    logic        ready_a, dvalid_a, ready_b, dvalid_b;
    logic [31:0] dout_a, dout_b;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    logic [31:0] ref_mem [256];
    int          cyc;
    logic        m_vld0, m_s1_v, m_vld1;
    logic [31:0] m_hold0, m_s1_d, m_hold1;

    always #5 clk0 = ~clk0;

    freepdk45_sram_1w1r_param #(.OUT_REG(0)) u_dut (
        .clk0(clk0), .rstb0(rstb0), .ready0(ready_a), .csb0(csb0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .csb1(csb1), .addr1(addr1),
        .dout1(dout_a), .dvalid1(dvalid_a)
    );

    freepdk45_sram_1w1r_param #(.OUT_REG(1)) u_dut_r (
        .clk0(clk0), .rstb0(rstb0), .ready0(ready_b), .csb0(csb0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .csb1(csb1), .addr1(addr1),
        .dout1(dout_b), .dvalid1(dvalid_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic rdy;
        rdy = (cyc >= 256);
        chk("ready_a",  {31'd0, ready_a},  {31'd0, rdy});
        chk("ready_b",  {31'd0, ready_b},  {31'd0, rdy});
        chk("dvalid_a", {31'd0, dvalid_a}, {31'd0, m_vld0});
        chk("dout_a",   dout_a,            m_hold0);
        chk("dvalid_b", {31'd0, dvalid_b}, {31'd0, m_vld1});
        chk("dout_b",   dout_b,            m_hold1);
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic wr, input logic [3:0] m, input logic [7:0] wa,
                        input logic [31:0] wd, input logic rd, input logic [7:0] ra);
        logic        acc_wr, acc_rd;
        logic [31:0] res;
        csb0 = ~wr; wmask0 = m; addr0 = wa; din0 = wd;
        csb1 = ~rd; addr1 = ra;
        acc_wr = wr && (cyc >= 256);
        acc_rd = rd && (cyc >= 256);
        res = ref_mem[ra];
        if (acc_wr && (wa == ra)) begin
            for (int i = 0; i < 4; i++) if (m[i]) res[i*8 +: 8] = wd[i*8 +: 8];
        end
        @(posedge clk0);
        #1;
        if (acc_wr) begin
            for (int i = 0; i < 4; i++) if (m[i]) ref_mem[wa][i*8 +: 8] = wd[i*8 +: 8];
        end
        cyc++;
        if (cyc == 256) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        end
        m_vld1 = m_s1_v;
        if (m_s1_v) m_hold1 = m_s1_d;
        m_s1_v = acc_rd;
        m_s1_d = res;
        m_vld0 = acc_rd;
        if (acc_rd) m_hold0 = res;
        check_outputs();
    endtask

    task automatic rand_step(input int amax);
        step(1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom_range(amax)),
             $urandom, 1'($urandom_range(1)), 8'($urandom_range(amax)));
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
    endtask

    // Called just after a rising edge; finishes before the next one.
    task automatic apply_reset();
        csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
        rstb0 = 1'b0;
        #1;
        cyc = 0;
        m_vld0 = 1'b0; m_hold0 = '0; m_s1_v = 1'b0; m_s1_d = '0;
        m_vld1 = 1'b0; m_hold1 = '0;
        check_outputs();
        #2;
        rstb0 = 1'b1;
    endtask

    initial begin
        rstb0 = 1'b0;
        csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        @(posedge clk0);
        #1;
        apply_reset();

        // Abort the clear sweep at cycle 100; accesses meanwhile are ignored.
        for (int i = 0; i < 100; i++) rand_step(255);
        apply_reset();
        for (int i = 0; i < 255; i++) rand_step(255);
        chk("ready_low_255", {31'd0, ready_a}, 32'd0);
        rand_step(255);
        chk("ready_high_256", {31'd0, ready_a}, 32'd1);

        step(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'hFF);
        chk("rd_ff_valid", {31'd0, dvalid_a}, 32'd1);
        chk("rd_ff_data", dout_a, 32'h0000_0000);

        step(1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF, 1'b0, 8'h00);
        step(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10);
        chk("full_write", dout_a, 32'hDEAD_BEEF);
        step(1'b1, 4'h2, 8'h10, 32'h0000_1100, 1'b0, 8'h00);
        step(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10);
        chk("lane1_write", dout_a, 32'hDEAD_11EF);
        step(1'b1, 4'h3, 8'h20, 32'h1234_5678, 1'b1, 8'h20);
        chk("collision", dout_a, 32'h0000_5678);
        idle();
        idle();

        step(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10);
        chk("oreg_v_c0", {31'd0, dvalid_b}, 32'd0);
        step(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h11);
        chk("oreg_v_c1", {31'd0, dvalid_b}, 32'd1);
        chk("oreg_d_c1", dout_b, 32'hDEAD_11EF);
        idle();
        chk("oreg_v_c2", {31'd0, dvalid_b}, 32'd1);
        chk("oreg_d_c2", dout_b, 32'h0000_0000);
        chk("hold_v_a", {31'd0, dvalid_a}, 32'd0);
        idle();
        chk("oreg_v_c3", {31'd0, dvalid_b}, 32'd0);

        // Dense traffic over a narrow address range to provoke collisions.
        for (int i = 0; i < 2000; i++) rand_step(15);
        for (int i = 0; i < 300; i++) rand_step(255);

        // Reset mid-traffic; the sweep must zero everything again.
        apply_reset();
        for (int i = 0; i < 256; i++) rand_step(15);
        for (int a = 0; a < 16; a++) begin
            step(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'(a));
            chk("cleared", dout_a, 32'h0);
        end
        for (int i = 0; i < 200; i++) rand_step(15);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/freepdk45_sram_1w1r_param.md
FREEPDK45_SRAM_1W1R_PARAM -- requirements
Module: freepdk45_sram_1w1r_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter WMASK_WIDTH, default 4, write-lane count; DATA_WIDTH SHALL be an integer multiple of it.
REQ-004 SHALL have parameter OUT_REG, default 0; 0 = 1-cycle read latency, 1 = 2-cycle read latency.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero the whole array after reset.
REQ-006 SHALL have port clk0, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rstb0, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port ready0, output, 1 bit: array accepts accesses.
REQ-009 SHALL have port csb0, input, 1 bit: write-port select, active low.
REQ-010 SHALL have port wmask0, input, WMASK_WIDTH bits: per-lane write enable, active high.
REQ-011 SHALL have port addr0, input, ADDR_WIDTH bits: write address.
REQ-012 SHALL have port din0, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port csb1, input, 1 bit: read-port select, active low.
REQ-014 SHALL have port addr1, input, ADDR_WIDTH bits: read address.
REQ-015 SHALL have port dout1, output, DATA_WIDTH bits: read data.
REQ-016 SHALL have port dvalid1, output, 1 bit: dout1 carries fresh read data this cycle.

Function
REQ-017 SHALL be fully synchronous to clk0; X SHALL never be driven on any output.
REQ-018 SHALL use two states, ST_CLEAR and ST_READY; ready0 SHALL be 1 only in ST_READY.
REQ-019 ST_CLEAR SHALL write zero to one address per cycle, counter 0 up to depth-1, then go to ST_READY on the next edge; with defaults, ready0 rises exactly 256 cycles after reset deassertion.
REQ-020 When CLEAR_ON_RESET=0, reset SHALL enter ST_READY directly; array contents are then undefined.
REQ-021 Write: on an edge with ready0=1 and csb0=0, each lane i with wmask0[i]=1 SHALL be updated from din0; other lanes are unchanged; wmask0=0 means no change.
REQ-022 Read: on an edge with ready0=1 and csb1=0, dout1 SHALL present mem[addr1] after the first edge when OUT_REG=0, or after the second edge when OUT_REG=1; dvalid1 is high for exactly that one cycle per read.
REQ-023 Back-to-back reads, one per cycle, SHALL be supported at full throughput.
REQ-024 dout1 SHALL hold its last value when no read is in flight.
REQ-025 Same-address collision (write and read on one edge, addr0==addr1) SHALL be write-first: enabled lanes return din0, masked-off lanes return the old contents.
REQ-026 Accesses presented while ready0=0 SHALL be ignored: no write, no dvalid1.
REQ-027 Addresses SHALL wrap naturally modulo depth; no out-of-range condition exists.

Reset
REQ-028 While rstb0=0: ready0=0, dvalid1=0, dout1=0, clear counter=0, all read pipeline stages invalid.
REQ-029 Reset asserted mid-clear or mid-read SHALL abort immediately; after release the full clear sequence restarts from address 0.
REQ-030 The memory array itself SHALL NOT be asynchronously reset; only the clear sequence zeroes it.

Structure
REQ-031 Package freepdk45_sram_pkg SHALL hold the state typedef (ST_CLEAR, ST_READY) and the lane-width helper function.
REQ-032 Sub-module freepdk45_sram_clear_fsm SHALL contain the state register, the clear counter and ready0; the top level holds the array, mask merge, bypass and read pipeline.

Verification
REQ-033 Defaults, release reset -> ready0=0 for 256 cycles then 1; read 0xFF -> dout1=0x00000000, dvalid1 pulses one cycle later.
REQ-034 Write 0x10 / 0xDEADBEEF / mask 0xF, then read 0x10 next cycle -> dout1=0xDEADBEEF one cycle after the read edge.
REQ-035 Then write 0x10 / 0x00001100 / mask 0x2; read 0x10 -> dout1=0xDEAD11EF.
REQ-036 Same edge: write 0x20 / 0x12345678 / mask 0x3 and read 0x20, with the old value 0 -> dout1=0x00005678.
REQ-037 Assert rstb0 at clear cycle 100 -> outputs zero at once; after release ready0 stays low for a further 256 cycles.
REQ-038 OUT_REG=1, reads of 0x10 and 0x11 on consecutive edges -> dvalid1 high on the two cycles starting 2 cycles after the first read, with correct data on each.
